// File: rtl/video_pkg.sv
// Shared types, colour table and raster-size helpers for the video pattern generator.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_SOLID = 2'd3
  } pattern_mode_e;

  localparam int LFSR_W = 24;

  // {r,g,b} full-scale flags; element 0 is the leftmost bar (white ... black)
  localparam logic [7:0][2:0] BAR_COLOUR = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int cnt_width(input int total);
    return (total <= 8) ? 3 : $clog2(total);
  endfunction

  function automatic int bar_width(input int h_active);
    return (h_active < 16) ? 1 : h_active / 8;
  endfunction

  // Only the low 23 bits survive the shift, so the MSB is not an argument.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-2:0] l);
    return {l, l[3] ^ l[8] ^ l[13] ^ l[22]};
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster position counters plus active/sync/frame markers decoded from the registered counter state.
module video_timing_core
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          hs_active,
  output logic          vs_active,
  output logic          frame_start,
  output logic          last_active
);

  localparam int H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  int   h_pos;
  int   v_pos;
  logic h_wrap;
  logic v_wrap;

  assign h_pos  = int'(x);
  assign v_pos  = int'(y);
  assign h_wrap = (h_pos == H_TOTAL - 1);
  assign v_wrap = (v_pos == V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (h_wrap) begin
      x <= '0;
      y <= v_wrap ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  // vs decodes v only, so it naturally changes at the h wrap.
  assign active      = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign hs_active   = (h_pos >= HS_START) && (h_pos < HS_END);
  assign vs_active   = (v_pos >= VS_START) && (v_pos < VS_END);
  assign frame_start = (h_pos == 0) && (v_pos == 0);
  assign last_active = (h_pos == H_ACTIVE - 1) && (v_pos == V_ACTIVE - 1);

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern source: LFSR noise, colour bars, ramp or solid colour selected per frame,
// with every output registered one clock after the raster counters.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int              COLORDEPTH  = 8,
  parameter int              H_ACTIVE    = 640,
  parameter int              H_FP        = 16,
  parameter int              H_SYNC      = 96,
  parameter int              H_BP        = 48,
  parameter int              V_ACTIVE    = 480,
  parameter int              V_FP        = 10,
  parameter int              V_SYNC      = 2,
  parameter int              V_BP        = 33,
  parameter bit              HS_POL      = 1'b0,
  parameter bit              VS_POL      = 1'b0,
  parameter logic [23:0]     LFSR_SEED   = 24'had98b7,
  parameter bit              LFSR_RESEED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode_i,
  input  logic [3*COLORDEPTH-1:0] solid_i,
  output logic [COLORDEPTH-1:0]   red_o,
  output logic [COLORDEPTH-1:0]   green_o,
  output logic [COLORDEPTH-1:0]   blue_o,
  output logic                    dv_o,
  output logic                    hs_o,
  output logic                    vs_o,
  output logic                    frame_start_o,
  output logic [15:0]             frame_cnt_o
);

  localparam int CD    = COLORDEPTH;
  localparam int XW    = cnt_width(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int YW    = cnt_width(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int BAR_W = bar_width(H_ACTIVE);

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              active;
  logic              hs_active;
  logic              vs_active;
  logic              frame_start;
  logic              last_active;
  pattern_mode_e     mode_shadow;
  pattern_mode_e     mode_eff;
  logic [3*CD-1:0]   solid_shadow;
  logic [3*CD-1:0]   solid_eff;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_cur;
  logic [XW-1:0]     bar_div;
  logic [2:0]        bar_idx;
  logic [2:0]        bar_rgb;
  logic [CD-1:0]     x_c;
  logic [CD-1:0]     y_c;
  logic [CD-1:0]     lfsr_r;
  logic [CD-1:0]     lfsr_g;
  logic [CD-1:0]     lfsr_b;
  logic [CD-1:0]     red_nxt;
  logic [CD-1:0]     green_nxt;
  logic [CD-1:0]     blue_nxt;
  logic [15:0]       frame_cnt;

  video_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .XW       (XW),
    .YW       (YW)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .active      (active),
    .hs_active   (hs_active),
    .vs_active   (vs_active),
    .frame_start (frame_start),
    .last_active (last_active)
  );

  // The origin pixel already uses the freshly sampled inputs; the shadow holds them for the rest
  // of the frame. After reset the counters sit at the origin, so the first edge samples mode_i.
  assign mode_eff  = frame_start ? pattern_mode_e'(mode_i) : mode_shadow;
  assign solid_eff = frame_start ? solid_i : solid_shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_shadow  <= MODE_LFSR;
      solid_shadow <= '0;
    end else if (frame_start) begin
      mode_shadow  <= pattern_mode_e'(mode_i);
      solid_shadow <= solid_i;
    end
  end

  assign lfsr_cur = (LFSR_RESEED && frame_start) ? LFSR_SEED : lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (active) begin
      lfsr_q <= lfsr_next(lfsr_cur[LFSR_W-2:0]);
    end
  end

  // Byte-wide LFSR fields are MSB-aligned into CD bits: truncated when narrower, zero-padded when wider.
  assign lfsr_r = CD'({lfsr_cur[23:16], {CD{1'b0}}} >> 8);
  assign lfsr_g = CD'({lfsr_cur[15:8],  {CD{1'b0}}} >> 8);
  assign lfsr_b = CD'({lfsr_cur[7:0],   {CD{1'b0}}} >> 8);

  assign bar_div = x / XW'(BAR_W);
  assign bar_idx = (bar_div > XW'(7)) ? 3'd7 : bar_div[2:0];
  assign bar_rgb = BAR_COLOUR[bar_idx];

  assign x_c = CD'(x);
  assign y_c = CD'(y);

  always_comb begin
    red_nxt   = '0;
    green_nxt = '0;
    blue_nxt  = '0;
    if (active) begin
      case (mode_eff)
        MODE_LFSR: begin
          red_nxt   = lfsr_r;
          green_nxt = lfsr_g;
          blue_nxt  = lfsr_b;
        end
        MODE_BARS: begin
          red_nxt   = {CD{bar_rgb[2]}};
          green_nxt = {CD{bar_rgb[1]}};
          blue_nxt  = {CD{bar_rgb[0]}};
        end
        MODE_RAMP: begin
          red_nxt   = x_c;
          green_nxt = y_c;
          blue_nxt  = x_c + y_c;
        end
        default: begin
          red_nxt   = solid_eff[3*CD-1:2*CD];
          green_nxt = solid_eff[2*CD-1:CD];
          blue_nxt  = solid_eff[CD-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      dv_o          <= 1'b0;
      hs_o          <= ~HS_POL;
      vs_o          <= ~VS_POL;
      frame_start_o <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      red_o         <= red_nxt;
      green_o       <= green_nxt;
      blue_o        <= blue_nxt;
      dv_o          <= active;
      hs_o          <= hs_active ? HS_POL : ~HS_POL;
      vs_o          <= vs_active ? VS_POL : ~VS_POL;
      frame_start_o <= frame_start;
      if (last_active) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 14x7 raster (8 active pixels, 4 active lines).
module tb_video_pattern_gen;

  localparam int CD = 8;

  logic          clk;
  logic          rst;
  logic [1:0]    mode_i;
  logic [3*CD-1:0] solid_i;
  logic [CD-1:0] red_o;
  logic [CD-1:0] green_o;
  logic [CD-1:0] blue_o;
  logic          dv_o;
  logic          hs_o;
  logic          vs_o;
  logic          frame_start_o;
  logic [15:0]   frame_cnt_o;
  logic [23:0]   rgb;

  int   k;
  int   total;
  int   bad;
  int   dv_cnt;
  int   dv_line0;
  int   dv_rise;
  int   hs_cnt;
  int   vs_cnt;
  int   fs_cnt;
  int   fs_first;
  int   fs_second;
  logic prev_dv;

  assign rgb = {red_o, green_o, blue_o};

  video_pattern_gen #(
    .COLORDEPTH  (CD),
    .H_ACTIVE    (8),
    .H_FP        (2),
    .H_SYNC      (2),
    .H_BP        (2),
    .V_ACTIVE    (4),
    .V_FP        (1),
    .V_SYNC      (1),
    .V_BP        (1),
    .HS_POL      (1'b0),
    .VS_POL      (1'b0),
    .LFSR_SEED   (24'had98b7),
    .LFSR_RESEED (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode_i        (mode_i),
    .solid_i       (solid_i),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .dv_o          (dv_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .frame_start_o (frame_start_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] lfsr_at(input int n);
    logic [23:0] l;
    l = 24'had98b7;
    for (int i = 0; i < n; i++) l = {l[22:0], l[3] ^ l[8] ^ l[13] ^ l[22]};
    return l;
  endfunction

  task automatic applyStimulus(input logic [1:0] mode, input logic [23:0] solid);
    mode_i  = mode;
    solid_i = solid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // k counts rising edges since the last reset release; sampling happens on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic runTo(input int target);
    while (k < target) step();
  endtask

  initial begin
    total = 0; bad = 0; k = 0;
    dv_cnt = 0; dv_line0 = 0; dv_rise = 0; hs_cnt = 0; vs_cnt = 0;
    fs_cnt = 0; fs_first = 0; fs_second = 0; prev_dv = 1'b0;
    rst = 1'b1;
    applyStimulus(2'd0, 24'h0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dv", dv_o, 0);
    checkOutput("rst_hs", hs_o, 1);
    checkOutput("rst_vs", vs_o, 1);
    checkOutput("rst_rgb", rgb, 0);
    checkOutput("rst_fs", frame_start_o, 0);
    checkOutput("rst_fcnt", frame_cnt_o, 0);

    rst = 1'b1;
    for (int i = 0; i < 294; i++) begin
      step();
      if (dv_o) dv_cnt++;
      if (dv_o && k <= 14) dv_line0++;
      if (dv_o && !prev_dv) dv_rise++;
      prev_dv = dv_o;
      if (!hs_o) hs_cnt++;
      if (!vs_o) vs_cnt++;
      if (frame_start_o) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = k;
        else if (fs_cnt == 2) fs_second = k;
      end
      case (k)
        1: begin
          checkOutput("lfsr_px0", rgb, 24'had98b7);
          checkOutput("fs_px0", frame_start_o, 1);
          checkOutput("dv_px0", dv_o, 1);
        end
        2: begin
          checkOutput("lfsr_px1", rgb, 24'h5b316e);
          checkOutput("fs_px1", frame_start_o, 0);
        end
        9: begin
          checkOutput("blank_dv", dv_o, 0);
          checkOutput("blank_rgb", rgb, 0);
        end
        10: checkOutput("hs_c10", hs_o, 1);
        11: checkOutput("hs_c11", hs_o, 0);
        12: checkOutput("hs_c12", hs_o, 0);
        13: checkOutput("hs_c13", hs_o, 1);
        20: checkOutput("lfsr_px13", rgb, lfsr_at(13));
        49: checkOutput("fcnt_before", frame_cnt_o, 0);
        50: checkOutput("fcnt_after", frame_cnt_o, 1);
        70: checkOutput("vs_c70", vs_o, 1);
        71: checkOutput("vs_c71", vs_o, 0);
        84: checkOutput("vs_c84", vs_o, 0);
        85: checkOutput("vs_c85", vs_o, 1);
        99: begin
          checkOutput("reseed_px0", rgb, 24'had98b7);
          checkOutput("fs_frame2", frame_start_o, 1);
        end
        default: ;
      endcase
    end
    checkOutput("dv_total", dv_cnt, 96);
    checkOutput("dv_line0", dv_line0, 8);
    checkOutput("dv_lines", dv_rise, 12);
    checkOutput("hs_total", hs_cnt, 42);
    checkOutput("vs_total", vs_cnt, 42);
    checkOutput("fs_total", fs_cnt, 3);
    checkOutput("fs_period", fs_second - fs_first, 98);
    checkOutput("fcnt_3", frame_cnt_o, 3);

    applyStimulus(2'd1, 24'h0);
    runTo(295);
    checkOutput("bar_x0", rgb, 24'hffffff);
    checkOutput("bar_fs", frame_start_o, 1);
    runTo(296);
    checkOutput("bar_x1", rgb, 24'hffff00);
    runTo(300);
    checkOutput("bar_x5", rgb, 24'hff0000);
    runTo(302);
    checkOutput("bar_x7", rgb, 24'h000000);
    checkOutput("bar_x7_dv", dv_o, 1);

    applyStimulus(2'd0, 24'h0);
    runTo(393);
    checkOutput("lfsr_f4_px0", rgb, 24'had98b7);
    runTo(409);
    applyStimulus(2'd2, 24'h0);
    runTo(412);
    checkOutput("switch_x5y1", rgb, lfsr_at(13));
    runTo(424);
    checkOutput("switch_x3y2", rgb, lfsr_at(19));
    runTo(442);
    checkOutput("switch_x7y3", rgb, lfsr_at(31));
    runTo(491);
    checkOutput("ramp_x0y0", rgb, 24'h000000);
    checkOutput("ramp_dv", dv_o, 1);
    runTo(510);
    checkOutput("ramp_x5y1", rgb, 24'h050106);
    runTo(535);
    checkOutput("ramp_x2y3", rgb, 24'h020305);

    applyStimulus(2'd3, 24'h123456);
    runTo(589);
    checkOutput("solid_px0", rgb, 24'h123456);
    checkOutput("fcnt_6", frame_cnt_o, 6);
    runTo(590);
    checkOutput("fs_single", frame_start_o, 0);
    applyStimulus(2'd3, 24'habcdef);
    force dut.frame_cnt = 16'hffff;
    #1 release dut.frame_cnt;
    runTo(607);
    checkOutput("solid_held", rgb, 24'h123456);
    runTo(637);
    checkOutput("fcnt_ffff", frame_cnt_o, 16'hffff);
    runTo(638);
    checkOutput("fcnt_wrap", frame_cnt_o, 16'h0000);

    runTo(669);
    checkOutput("pre_rst_hs", hs_o, 0);
    checkOutput("pre_rst_vs", vs_o, 0);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_hs", hs_o, 1);
    checkOutput("mid_rst_vs", vs_o, 1);
    checkOutput("mid_rst_dv", dv_o, 0);
    checkOutput("mid_rst_rgb", rgb, 0);
    checkOutput("mid_rst_fcnt", frame_cnt_o, 0);
    applyStimulus(2'd0, 24'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k = 0;
    runTo(1);
    checkOutput("rel_px0", rgb, 24'had98b7);
    checkOutput("rel_fs", frame_start_o, 1);
    runTo(10);
    checkOutput("rel_hs_c10", hs_o, 1);
    runTo(11);
    checkOutput("rel_hs_c11", hs_o, 0);
    runTo(12);
    checkOutput("rel_hs_c12", hs_o, 0);
    runTo(13);
    checkOutput("rel_hs_c13", hs_o, 1);
    runTo(20);
    checkOutput("act_pre_rst_dv", dv_o, 1);
    checkOutput("act_pre_rst_rgb", rgb, lfsr_at(13));
    #1 rst = 1'b0;
    #1;
    checkOutput("act_rst_dv", dv_o, 0);
    checkOutput("act_rst_rgb", rgb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
